// File: rtl/relu_stream_layer.sv
// rtl/relu_stream_layer.sv - streaming per-lane activation stage (bypass/ReLU/leaky/clipped) with frame accounting
module relu_stream_layer #(
    parameter int DATA_WIDTH = 45,
    parameter int OUT_WIDTH  = 16,
    parameter int CHANNELS   = 8,
    parameter int FRAME_X    = 24,
    parameter int FRAME_Y    = 24,
    parameter int IN_SHIFT   = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [CHANNELS*DATA_WIDTH-1:0]  in_data,
    input  logic [1:0]                      mode,
    input  logic [3:0]                      leak_shift,
    input  logic [OUT_WIDTH-2:0]            clip_max,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [CHANNELS*OUT_WIDTH-1:0]   out_data,
    output logic                            out_last,
    output logic                            relu_done,
    output logic                            sat_flag
);

    localparam int NBEATS = FRAME_X * FRAME_Y;
    localparam int CW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(NBEATS - 1);

    localparam logic signed [DATA_WIDTH-1:0] SAT_MAX =
        {{(DATA_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] SAT_MIN =
        {{(DATA_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
    localparam logic [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    // Rescale, then apply the leaky slope to negatives; the result is the value to be saturated.
    function automatic logic signed [DATA_WIDTH-1:0] pre_act(
        input logic signed [DATA_WIDTH-1:0] x,
        input logic [1:0]                   m,
        input logic [3:0]                   ls
    );
        logic signed [DATA_WIDTH-1:0] s;
        s = x >>> IN_SHIFT;
        if (s[DATA_WIDTH-1] && (m == 2'd2)) begin
            return s >>> ls;
        end
        return s;
    endfunction

    // Saturate to the output width and apply the clip ceiling; returns {sat_hit, y}.
    function automatic logic [OUT_WIDTH:0] act_out(
        input logic signed [DATA_WIDTH-1:0] v,
        input logic                         zero,
        input logic                         clip_en,
        input logic [OUT_WIDTH-2:0]         cm
    );
        logic [OUT_WIDTH-1:0] y;
        logic                 hit;
        y   = v[OUT_WIDTH-1:0];
        hit = 1'b0;
        if (zero) begin
            y = '0;
        end else begin
            if (v > SAT_MAX) begin
                y   = OUT_MAX;
                hit = 1'b1;
            end else if (v < SAT_MIN) begin
                y   = OUT_MIN;
                hit = 1'b1;
            end
            // Non-zeroed lanes in clip mode are non-negative, so an unsigned compare is exact.
            if (clip_en && (y > {1'b0, cm})) begin
                y = {1'b0, cm};
            end
        end
        return {hit, y};
    endfunction

    // Registered state
    logic                           ready_ok_q, ready_ok_d;
    logic [CW-1:0]                  cnt_q, cnt_d;
    logic [1:0]                     cfg_mode_q, cfg_mode_d;
    logic [3:0]                     cfg_leak_q, cfg_leak_d;
    logic [OUT_WIDTH-2:0]           cfg_clip_q, cfg_clip_d;

    logic                           cap_valid_q, cap_valid_d;
    logic                           cap_last_q, cap_last_d;
    logic [CHANNELS*DATA_WIDTH-1:0] cap_data_q, cap_data_d;
    logic [1:0]                     cap_mode_q, cap_mode_d;
    logic [3:0]                     cap_leak_q, cap_leak_d;
    logic [OUT_WIDTH-2:0]           cap_clip_q, cap_clip_d;

    logic                           s1_valid_q, s1_valid_d;
    logic                           s1_last_q, s1_last_d;
    logic [CHANNELS*DATA_WIDTH-1:0] s1_val_q, s1_val_d;
    logic [CHANNELS-1:0]            s1_zero_q, s1_zero_d;
    logic                           s1_clip_en_q, s1_clip_en_d;
    logic [OUT_WIDTH-2:0]           s1_clip_q, s1_clip_d;

    logic                           out_valid_q, out_valid_d;
    logic                           out_last_q, out_last_d;
    logic [CHANNELS*OUT_WIDTH-1:0]  out_data_q, out_data_d;
    logic                           done_q, done_d;
    logic                           sat_q, sat_d;

    // Combinational lane results
    logic [CHANNELS*DATA_WIDTH-1:0] s1_val_c;
    logic [CHANNELS-1:0]            s1_zero_c;
    logic [CHANNELS*OUT_WIDTH-1:0]  y_c;
    logic [CHANNELS-1:0]            hit_c;

    logic en, accept, first_beat, last_beat;

    assign en         = !out_valid_q || out_ready;
    assign in_ready   = ready_ok_q && en;
    assign accept     = in_valid && in_ready;
    assign first_beat = (cnt_q == '0);
    assign last_beat  = (cnt_q == LAST_IDX);

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_last   = out_last_q;
    assign relu_done  = done_q;
    assign sat_flag   = sat_q;

    // Stage 1 lane math: rescale, leaky slope, and whether the lane is forced to zero.
    always_comb begin
        s1_val_c  = '0;
        s1_zero_c = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            s1_val_c[c*DATA_WIDTH +: DATA_WIDTH] =
                pre_act(cap_data_q[c*DATA_WIDTH +: DATA_WIDTH], cap_mode_q, cap_leak_q);
            s1_zero_c[c] = s1_val_c[c*DATA_WIDTH + DATA_WIDTH - 1] && cap_mode_q[0];
        end
    end

    // Stage 2 lane math: saturation and clip ceiling, with per-lane saturation hits.
    always_comb begin
        logic [OUT_WIDTH:0] r;
        r     = '0;
        y_c   = '0;
        hit_c = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            r = act_out(s1_val_q[c*DATA_WIDTH +: DATA_WIDTH], s1_zero_q[c],
                        s1_clip_en_q, s1_clip_q);
            y_c[c*OUT_WIDTH +: OUT_WIDTH] = r[OUT_WIDTH-1:0];
            hit_c[c] = r[OUT_WIDTH];
        end
    end

    // Next-state: beat counter, frame config latch, pipeline advance on en, done/sat flags.
    always_comb begin
        ready_ok_d   = 1'b1;
        cnt_d        = cnt_q;
        cfg_mode_d   = cfg_mode_q;
        cfg_leak_d   = cfg_leak_q;
        cfg_clip_d   = cfg_clip_q;
        cap_valid_d  = cap_valid_q;
        cap_last_d   = cap_last_q;
        cap_data_d   = cap_data_q;
        cap_mode_d   = cap_mode_q;
        cap_leak_d   = cap_leak_q;
        cap_clip_d   = cap_clip_q;
        s1_valid_d   = s1_valid_q;
        s1_last_d    = s1_last_q;
        s1_val_d     = s1_val_q;
        s1_zero_d    = s1_zero_q;
        s1_clip_en_d = s1_clip_en_q;
        s1_clip_d    = s1_clip_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        out_data_d   = out_data_q;
        done_d       = out_valid_q && out_ready && out_last_q;
        sat_d        = sat_q;

        if (accept) begin
            cnt_d = last_beat ? '0 : cnt_q + CW'(1);
            if (first_beat) begin
                cfg_mode_d = mode;
                cfg_leak_d = leak_shift;
                cfg_clip_d = clip_max;
                sat_d      = 1'b0;
            end
        end

        if (en) begin
            // Each beat carries its frame's config so a frame boundary mid-pipeline is exact.
            cap_valid_d = accept;
            cap_last_d  = accept && last_beat;
            if (accept) begin
                cap_data_d = in_data;
                cap_mode_d = first_beat ? mode       : cfg_mode_q;
                cap_leak_d = first_beat ? leak_shift : cfg_leak_q;
                cap_clip_d = first_beat ? clip_max   : cfg_clip_q;
            end

            s1_valid_d = cap_valid_q;
            s1_last_d  = cap_valid_q && cap_last_q;
            if (cap_valid_q) begin
                s1_val_d     = s1_val_c;
                s1_zero_d    = s1_zero_c;
                s1_clip_en_d = (cap_mode_q == 2'd3);
                s1_clip_d    = cap_clip_q;
            end

            out_valid_d = s1_valid_q;
            out_last_d  = s1_valid_q && s1_last_q;
            if (s1_valid_q) begin
                out_data_d = y_c;
                if (|hit_c) begin
                    sat_d = 1'b1;
                end
            end
        end
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_ok_q   <= 1'b0;
            cnt_q        <= '0;
            cfg_mode_q   <= '0;
            cfg_leak_q   <= '0;
            cfg_clip_q   <= '0;
            cap_valid_q  <= 1'b0;
            cap_last_q   <= 1'b0;
            cap_data_q   <= '0;
            cap_mode_q   <= '0;
            cap_leak_q   <= '0;
            cap_clip_q   <= '0;
            s1_valid_q   <= 1'b0;
            s1_last_q    <= 1'b0;
            s1_val_q     <= '0;
            s1_zero_q    <= '0;
            s1_clip_en_q <= 1'b0;
            s1_clip_q    <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_data_q   <= '0;
            done_q       <= 1'b0;
            sat_q        <= 1'b0;
        end else begin
            ready_ok_q   <= ready_ok_d;
            cnt_q        <= cnt_d;
            cfg_mode_q   <= cfg_mode_d;
            cfg_leak_q   <= cfg_leak_d;
            cfg_clip_q   <= cfg_clip_d;
            cap_valid_q  <= cap_valid_d;
            cap_last_q   <= cap_last_d;
            cap_data_q   <= cap_data_d;
            cap_mode_q   <= cap_mode_d;
            cap_leak_q   <= cap_leak_d;
            cap_clip_q   <= cap_clip_d;
            s1_valid_q   <= s1_valid_d;
            s1_last_q    <= s1_last_d;
            s1_val_q     <= s1_val_d;
            s1_zero_q    <= s1_zero_d;
            s1_clip_en_q <= s1_clip_en_d;
            s1_clip_q    <= s1_clip_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            out_data_q   <= out_data_d;
            done_q       <= done_d;
            sat_q        <= sat_d;
        end
    end

endmodule

// File: tb/tb_relu_stream_layer.sv
// tb/tb_relu_stream_layer.sv - directed self-checking bench for relu_stream_layer
module tb_relu_stream_layer;

    localparam int DW = 45;
    localparam int OW = 16;
    localparam int CH = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [CH*DW-1:0]  in_data = '0;
    logic [1:0]        mode = '0;
    logic [3:0]        leak_shift = '0;
    logic [OW-2:0]     clip_max = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [CH*OW-1:0]  out_data;
    logic              out_last;
    logic              relu_done;
    logic              sat_flag;

    int n_checks = 0;
    int n_fail   = 0;

    relu_stream_layer #(
        .DATA_WIDTH(DW), .OUT_WIDTH(OW), .CHANNELS(CH),
        .FRAME_X(2), .FRAME_Y(2), .IN_SHIFT(0)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .mode(mode), .leak_shift(leak_shift), .clip_max(clip_max),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .relu_done(relu_done), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    function automatic logic [CH*DW-1:0] pin(input int a0, input int a1, input int a2, input int a3,
                                             input int a4, input int a5, input int a6, input int a7);
        return {DW'(a7), DW'(a6), DW'(a5), DW'(a4), DW'(a3), DW'(a2), DW'(a1), DW'(a0)};
    endfunction

    function automatic logic [CH*OW-1:0] pout(input int a0, input int a1, input int a2, input int a3,
                                              input int a4, input int a5, input int a6, input int a7);
        return {OW'(a7), OW'(a6), OW'(a5), OW'(a4), OW'(a3), OW'(a2), OW'(a1), OW'(a0)};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic beat(input logic [CH*DW-1:0] d, input logic [1:0] m,
                        input logic [3:0] ls, input logic [OW-2:0] cm);
        in_valid   = 1'b1;
        in_data    = d;
        mode       = m;
        leak_shift = ls;
        clip_max   = cm;
        tick();
        in_valid   = 1'b0;
    endtask

    logic [CH*OW-1:0] prev_data;
    logic             prev_stall;
    int               sent;
    int               got;

    initial begin
        // Reset values
        tick();
        tick();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_relu_done", relu_done, 0);
        chk("rst_sat_flag", sat_flag, 0);
        rst = 1'b0;
        tick();
        chk("rst_release_ready", in_ready, 1);

        // ReLU with saturation, latency two edges after acceptance
        beat(pin(-5, 0, 7, 40000, -40000, 32767, 1, -1), 2'd1, 4'd0, 15'd0);
        chk("relu_lat_k", out_valid, 0);
        tick();
        chk("relu_lat_k1", out_valid, 0);
        tick();
        chk("relu_lat_k2", out_valid, 1);
        chk("relu_data", out_data, pout(0, 0, 7, 32767, 0, 32767, 1, 0));
        chk("relu_sat", sat_flag, 1);

        // Leaky frame; mid-frame mode change ignored; next frame bypass saturates
        do_reset();
        beat(pin(-100, -5, -1, 100, 0, 0, 0, 0), 2'd2, 4'd2, 15'd0);
        tick(); tick();
        chk("leaky_data", out_data, pout(-25, -2, -1, 100, 0, 0, 0, 0));
        chk("leaky_sat", sat_flag, 0);
        beat(pin(-8, 0, 0, 0, 0, 0, 0, 0), 2'd0, 4'd0, 15'd0);
        tick(); tick();
        chk("leaky_cfg_hold", out_data, pout(-2, 0, 0, 0, 0, 0, 0, 0));
        beat(pin(0, 0, 0, 0, 0, 0, 0, 0), 2'd0, 4'd0, 15'd0);
        beat(pin(0, 0, 0, 0, 0, 0, 0, 0), 2'd0, 4'd0, 15'd0);
        beat(pin(-40000, -8, 0, 0, 0, 0, 0, 0), 2'd0, 4'd0, 15'd0);
        tick(); tick();
        chk("bypass_sat_data", out_data, pout(-32768, -8, 0, 0, 0, 0, 0, 0));
        chk("bypass_sat_flag", sat_flag, 1);

        // Clipped ReLU
        do_reset();
        beat(pin(9, 3, -4, 6, 0, 0, 0, 0), 2'd3, 4'd0, 15'd6);
        tick(); tick();
        chk("clip_data", out_data, pout(6, 3, 0, 6, 0, 0, 0, 0));
        chk("clip_sat", sat_flag, 0);

        // Backpressure: 10 beats, out_ready low for cycles 3..7
        do_reset();
        mode = 2'd0;
        sent = 0;
        got = 0;
        prev_stall = 1'b0;
        prev_data = '0;
        for (int cyc = 0; cyc < 40 && got < 10; cyc++) begin
            out_ready = !(cyc >= 3 && cyc <= 7);
            in_valid  = (sent < 10);
            in_data   = pin(sent + 1, -(sent + 1), 0, 0, 0, 0, 0, 0);
            #1;
            chk("bp_in_ready", in_ready, !(out_valid && !out_ready));
            if (prev_stall) chk("bp_hold", out_data, prev_data);
            if (out_valid && out_ready) begin
                chk("bp_order", out_data, pout(got + 1, -(got + 1), 0, 0, 0, 0, 0, 0));
                got++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (in_valid && in_ready) sent++;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("bp_count", got, 10);
        tick(); tick(); tick();
        chk("bp_no_dup", out_valid, 0);

        // Two back-to-back 4-beat frames
        do_reset();
        for (int c = 0; c < 12; c++) begin
            in_valid = (c < 8);
            in_data  = pin((c == 1) ? 40000 : 10 * c + 1, -(c + 1), 0, 0, 0, 0, 0, 0);
            mode     = 2'd1;
            tick();
            if (c == 3) chk("fr_sat_set", sat_flag, 1);
            if (c == 4) chk("fr_sat_clear", sat_flag, 0);
            if (c == 5) begin
                chk("fr_last0", out_last, 1);
                chk("fr_last0_data", out_data, pout(31, 0, 0, 0, 0, 0, 0, 0));
                chk("fr_done_early", relu_done, 0);
            end
            if (c == 6) begin
                chk("fr_done0", relu_done, 1);
                chk("fr_last_drop", out_last, 0);
            end
            if (c == 7) chk("fr_done0_pulse", relu_done, 0);
            if (c == 9) begin
                chk("fr_last1", out_last, 1);
                chk("fr_last1_data", out_data, pout(71, 0, 0, 0, 0, 0, 0, 0));
            end
            if (c == 10) chk("fr_done1", relu_done, 1);
            if (c == 11) chk("fr_done1_pulse", relu_done, 0);
        end
        in_valid = 1'b0;

        // Reset mid-frame after beat 2
        do_reset();
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1;
            in_data  = pin((c == 0) ? 40000 : 5, 0, 0, 0, 0, 0, 0, 0);
            mode     = 2'd1;
            tick();
        end
        chk("mr_sat_before", sat_flag, 1);
        rst = 1'b1;
        in_valid = 1'b0;
        tick();
        chk("mr_out_valid", out_valid, 0);
        chk("mr_out_data", out_data, 0);
        chk("mr_out_last", out_last, 0);
        chk("mr_done", relu_done, 0);
        chk("mr_sat", sat_flag, 0);
        chk("mr_in_ready", in_ready, 0);
        rst = 1'b0;
        tick();
        chk("mr_ready_after", in_ready, 1);
        chk("mr_discard", out_valid, 0);
        for (int c = 0; c < 7; c++) begin
            in_valid = (c < 4);
            in_data  = pin(100 + c, 0, 0, 0, 0, 0, 0, 0);
            tick();
            if (c == 4) chk("mr_not_last", out_last, 0);
            if (c == 5) begin
                chk("mr_last", out_last, 1);
                chk("mr_last_data", out_data, pout(103, 0, 0, 0, 0, 0, 0, 0));
            end
        end
        in_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
